// File: rtl/alu_pipe_pkg.sv
// Shared opcodes, unit-flag indices, FSM states
// and compare codes for the alu_pipe datapath.
package alu_pipe_pkg;

  localparam logic [3:0] FUN_ADD   = 4'd0;
  localparam logic [3:0] FUN_SUB   = 4'd1;
  localparam logic [3:0] FUN_MUL   = 4'd2;
  localparam logic [3:0] FUN_DIV   = 4'd3;
  localparam logic [3:0] FUN_AND   = 4'd4;
  localparam logic [3:0] FUN_OR    = 4'd5;
  localparam logic [3:0] FUN_NAND  = 4'd6;
  localparam logic [3:0] FUN_NOR   = 4'd7;
  localparam logic [3:0] FUN_NOP   = 4'd8;
  localparam logic [3:0] FUN_EQ    = 4'd9;
  localparam logic [3:0] FUN_GT    = 4'd10;
  localparam logic [3:0] FUN_LT    = 4'd11;
  localparam logic [3:0] FUN_SHR_A = 4'd12;
  localparam logic [3:0] FUN_SHL_A = 4'd13;
  localparam logic [3:0] FUN_SHR_B = 4'd14;
  localparam logic [3:0] FUN_SHL_B = 4'd15;

  localparam int UF_ARITH = 0;
  localparam int UF_LOGIC = 1;
  localparam int UF_CMP   = 2;
  localparam int UF_SHIFT = 3;

  localparam logic [1:0] CMP_EQ = 2'd1;
  localparam logic [1:0] CMP_GT = 2'd2;
  localparam logic [1:0] CMP_LT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_DONE
  } state_t;

endpackage

// File: rtl/alu_div_iter.sv
// Unsigned radix-2 restoring divider; the start
// edge already performs the first of WIDTH steps.
module alu_div_iter #(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;

  function automatic logic [2*WIDTH-1:0] step(
    input logic [WIDTH-1:0] r,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] tr;
    sh = {r, q[WIDTH-1]};
    tr = sh[WIDTH-1:0] - d;
    if (sh >= {1'b0, d})
      return {tr, q[WIDTH-2:0], 1'b1};
    return {sh[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      dvs <= '0;
      rem <= '0;
      quo <= '0;
    end else if (start) begin
      {rem, quo} <= step('0, dividend, divisor);
      dvs <= divisor;
      cnt <= CNT_W'(WIDTH - 1);
    end else if (cnt != '0) begin
      {rem, quo} <= step(rem, quo, dvs);
      cnt <= cnt - CNT_W'(1);
    end
  end

  // high during the cycle whose edge runs the final step
  assign done      = (cnt == CNT_W'(1));
  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked 16-function ALU with registered result.
// ALU_DIV_EN enables the iterative signed divider.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [3:0]         ALU_FUN,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [2*WIDTH-1:0] RESULT,
  output logic [3:0]         UNIT_FLAG,
  output logic               OVF,
  output logic               DIV_ZERO,
  output logic               BUSY
);

  localparam int W2 = 2 * WIDTH;
  localparam int HX = WIDTH - 1;

  state_t              state;
  logic                ready_en;
  logic                out_valid_q;
  logic                ovf_q;
  logic                dz_q;
  logic [W2-1:0]       result_q;
  logic [3:0]          flag_q;
  logic [W2-1:0]       res_c;
  logic [3:0]          flag_c;
  logic                dz_c;
  logic                div_go;
  logic                accept;
  logic signed [WIDTH:0]  sum_c;
  logic signed [WIDTH:0]  dif_c;
  logic signed [W2-1:0]   prod_c;
  logic [WIDTH-1:0]    zh;

  function automatic logic cmp_hit(
    input logic [1:0]       code,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    unique case (code)
      CMP_EQ:  return a == b;
      CMP_GT:  return $signed(a) > $signed(b);
      CMP_LT:  return $signed(a) < $signed(b);
      default: return 1'b0;
    endcase
  endfunction

  assign zh = '0;
  assign IN_READY = ready_en
                 && (state == ST_IDLE)
                 && (!out_valid_q || OUT_READY);
  assign accept = IN_VALID && IN_READY;

  assign sum_c  = $signed({A[HX], A})
                + $signed({B[HX], B});
  assign dif_c  = $signed({A[HX], A})
                - $signed({B[HX], B});
  assign prod_c = $signed(A) * $signed(B);

  always_comb begin
    res_c  = '0;
    flag_c = '0;
    dz_c   = 1'b0;
    div_go = 1'b0;
    case (ALU_FUN)
      FUN_ADD: begin
        res_c = {{(WIDTH-1){sum_c[WIDTH]}}, sum_c};
        flag_c[UF_ARITH] = 1'b1;
      end
      FUN_SUB: begin
        res_c = {{(WIDTH-1){dif_c[WIDTH]}}, dif_c};
        flag_c[UF_ARITH] = 1'b1;
      end
      FUN_MUL: begin
        res_c = prod_c;
        flag_c[UF_ARITH] = 1'b1;
      end
      FUN_DIV: begin
        flag_c[UF_ARITH] = 1'b1;
`ifdef ALU_DIV_EN
        if (B == '0) dz_c = 1'b1;
        else div_go = 1'b1;
`else
        dz_c = 1'b1;
`endif
      end
      FUN_AND: begin
        res_c = {zh, A & B};
        flag_c[UF_LOGIC] = 1'b1;
      end
      FUN_OR: begin
        res_c = {zh, A | B};
        flag_c[UF_LOGIC] = 1'b1;
      end
      FUN_NAND: begin
        res_c = {zh, ~(A & B)};
        flag_c[UF_LOGIC] = 1'b1;
      end
      FUN_NOR: begin
        res_c = {zh, ~(A | B)};
        flag_c[UF_LOGIC] = 1'b1;
      end
      FUN_EQ: begin
        res_c[0] = cmp_hit(CMP_EQ, A, B);
        flag_c[UF_CMP] = 1'b1;
      end
      FUN_GT: begin
        res_c[0] = cmp_hit(CMP_GT, A, B);
        flag_c[UF_CMP] = 1'b1;
      end
      FUN_LT: begin
        res_c[0] = cmp_hit(CMP_LT, A, B);
        flag_c[UF_CMP] = 1'b1;
      end
      FUN_SHR_A: begin
        res_c = {zh, A >> 1};
        flag_c[UF_SHIFT] = 1'b1;
      end
      FUN_SHL_A: begin
        res_c = {zh, A << 1};
        flag_c[UF_SHIFT] = 1'b1;
      end
      FUN_SHR_B: begin
        res_c = {zh, B >> 1};
        flag_c[UF_SHIFT] = 1'b1;
      end
      FUN_SHL_B: begin
        res_c = {zh, B << 1};
        flag_c[UF_SHIFT] = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ALU_DIV_EN
  logic             a_neg;
  logic             b_neg;
  logic             ovf_pend;
  logic             div_done;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // |MIN| keeps its bit pattern, which is the
  // correct unsigned magnitude for the divider
  assign abs_a = A[HX] ? -A : A;
  assign abs_b = B[HX] ? -B : B;
  assign q_fix = (a_neg ^ b_neg) ? -div_q : div_q;
  assign r_fix = a_neg ? -div_r : div_r;

  alu_div_iter #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (CLK),
    .rst      (RST),
    .start    (accept && div_go),
    .dividend (abs_a),
    .divisor  (abs_b),
    .quotient (div_q),
    .remainder(div_r),
    .done     (div_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      ovf_pend <= 1'b0;
    end else if (accept && div_go) begin
      a_neg    <= A[HX];
      b_neg    <= B[HX];
      ovf_pend <= (A == {1'b1, {HX{1'b0}}}) && (&B);
    end
  end

  assign BUSY = (state != ST_IDLE);
`else
  assign BUSY = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      ready_en    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flag_q      <= '0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (OUT_READY) out_valid_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            if (div_go) begin
              state <= ST_DIV;
            end else begin
              result_q    <= res_c;
              flag_q      <= flag_c;
              ovf_q       <= 1'b0;
              dz_q        <= dz_c;
              out_valid_q <= 1'b1;
            end
          end
        end
`ifdef ALU_DIV_EN
        ST_DIV: begin
          if (div_done) state <= ST_DONE;
        end
        ST_DONE: begin
          result_q    <= {r_fix, q_fix};
          flag_q      <= 4'(1 << UF_ARITH);
          ovf_q       <= ovf_pend;
          dz_q        <= 1'b0;
          out_valid_q <= 1'b1;
          state       <= ST_IDLE;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign OUT_VALID = out_valid_q;
  assign RESULT    = result_q;
  assign UNIT_FLAG = flag_q;
  assign OVF       = ovf_q;
  assign DIV_ZERO  = dz_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and random checks of alu_pipe against
// an integer-arithmetic reference model.
module tb_alu_pipe;

  localparam int W = 16;
`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic           CLK = 1'b0;
  logic           RST;
  logic           IN_VALID;
  logic           IN_READY;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [3:0]     ALU_FUN;
  logic           OUT_VALID;
  logic           OUT_READY;
  logic [2*W-1:0] RESULT;
  logic [3:0]     UNIT_FLAG;
  logic           OVF;
  logic           DIV_ZERO;
  logic           BUSY;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  uf;
    logic        ovf;
    logic        dz;
    int          lat;
  } exp_t;

  alu_pipe #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .A        (A),
    .B        (B),
    .ALU_FUN  (ALU_FUN),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .RESULT   (RESULT),
    .UNIT_FLAG(UNIT_FLAG),
    .OVF      (OVF),
    .DIV_ZERO (DIV_ZERO),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic exp_t model(
    input logic [3:0]   f,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    exp_t e;
    int sa, sb, q, rm;
    logic [W-1:0] t;
    sa = int'($signed(a));
    sb = int'($signed(b));
    e.res = '0;
    e.uf  = '0;
    e.ovf = 1'b0;
    e.dz  = 1'b0;
    e.lat = 1;
    t = '0;
    case (f)
      4'd0: begin e.res = 32'(sa + sb); e.uf = 4'b0001; end
      4'd1: begin e.res = 32'(sa - sb); e.uf = 4'b0001; end
      4'd2: begin e.res = 32'(sa * sb); e.uf = 4'b0001; end
      4'd3: begin
        e.uf = 4'b0001;
        if (!DIV_EN || sb == 0) begin
          e.dz = 1'b1;
        end else begin
          q = sa / sb;
          rm = sa % sb;
          e.res = {rm[15:0], q[15:0]};
          e.ovf = (sa == -32768) && (sb == -1);
          e.lat = W + 1;
        end
      end
      4'd4: begin e.res = {16'h0, a & b}; e.uf = 4'b0010; end
      4'd5: begin e.res = {16'h0, a | b}; e.uf = 4'b0010; end
      4'd6: begin e.res = {16'h0, ~(a & b)}; e.uf = 4'b0010; end
      4'd7: begin e.res = {16'h0, ~(a | b)}; e.uf = 4'b0010; end
      4'd9:  begin e.res = 32'(sa == sb); e.uf = 4'b0100; end
      4'd10: begin e.res = 32'(sa > sb); e.uf = 4'b0100; end
      4'd11: begin e.res = 32'(sa < sb); e.uf = 4'b0100; end
      4'd12: begin t = a >> 1; e.res = {16'h0, t}; e.uf = 4'b1000; end
      4'd13: begin t = a << 1; e.res = {16'h0, t}; e.uf = 4'b1000; end
      4'd14: begin t = b >> 1; e.res = {16'h0, t}; e.uf = 4'b1000; end
      4'd15: begin t = b << 1; e.res = {16'h0, t}; e.uf = 4'b1000; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic idle();
    @(negedge CLK);
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_op(
    input logic [3:0]   f,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input string        tag
  );
    exp_t e;
    int lat, busy;
    bit rdy_seen;
    e = model(f, a, b);
    busy = 0;
    rdy_seen = 1'b0;
    @(negedge CLK);
    ALU_FUN   = f;
    A         = a;
    B         = b;
    IN_VALID  = 1'b1;
    OUT_READY = 1'b1;
    chk({tag, "/in_ready"}, IN_READY, 1);
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    lat = 1;
    while (!OUT_VALID && lat < 40) begin
      if (BUSY) busy++;
      if (IN_READY) rdy_seen = 1'b1;
      @(posedge CLK);
      #1;
      lat++;
    end
    chk({tag, "/latency"}, lat, e.lat);
    chk({tag, "/result"}, RESULT, e.res);
    chk({tag, "/unit"}, UNIT_FLAG, e.uf);
    chk({tag, "/ovf"}, OVF, e.ovf);
    chk({tag, "/dz"}, DIV_ZERO, e.dz);
    chk({tag, "/busy_cyc"}, busy, e.lat - 1);
    chk({tag, "/rdy_wait"}, rdy_seen, 0);
  endtask

  initial begin
    logic [3:0]   bf [3];
    logic [W-1:0] ba [3];
    logic [W-1:0] bb [3];
    exp_t e;
    logic [3:0]   rf;
    logic [W-1:0] ra, rb;

    RST = 1'b1;
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    A = '0;
    B = '0;
    ALU_FUN = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst/in_ready", IN_READY, 0);
    chk("rst/out_valid", OUT_VALID, 0);
    chk("rst/result", RESULT, 0);
    chk("rst/unit", UNIT_FLAG, 0);
    chk("rst/ovf", OVF, 0);
    chk("rst/dz", DIV_ZERO, 0);
    chk("rst/busy", BUSY, 0);
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_fall/in_ready_low", IN_READY, 0);
    @(posedge CLK);
    #1;
    chk("rst_fall/in_ready_high", IN_READY, 1);

    bf[0] = 4'd0; ba[0] = -16'sd2; bb[0] = -16'sd3;
    bf[1] = 4'd1; ba[1] = 16'd2;   bb[1] = -16'sd3;
    bf[2] = 4'd2; ba[2] = -16'sd2; bb[2] = 16'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      ALU_FUN   = bf[i];
      A         = ba[i];
      B         = bb[i];
      IN_VALID  = 1'b1;
      OUT_READY = 1'b1;
      chk($sformatf("b2b%0d/in_ready", i), IN_READY, 1);
      @(posedge CLK);
      #1;
      e = model(bf[i], ba[i], bb[i]);
      chk($sformatf("b2b%0d/valid", i), OUT_VALID, 1);
      chk($sformatf("b2b%0d/result", i), RESULT, e.res);
      chk($sformatf("b2b%0d/unit", i), UNIT_FLAG, e.uf);
    end
    idle();

    do_op(4'd3, -16'sd7, 16'd2, "div_m7_2");
    do_op(4'd3, 16'd5, 16'd0, "div_5_0");
    do_op(4'd3, 16'h8000, 16'hFFFF, "div_min_m1");
    do_op(4'd3, 16'd100, -16'sd7, "div_100_m7");
    do_op(4'd4, 16'd3, 16'd2, "and");
    do_op(4'd6, 16'd3, 16'd2, "nand");
    do_op(4'd5, 16'h00F0, 16'h0F00, "or");
    do_op(4'd7, 16'h00F0, 16'h0F00, "nor");
    do_op(4'd10, 16'd3, 16'd2, "gt");
    do_op(4'd11, 16'd3, 16'd2, "lt");
    do_op(4'd9, 16'h8000, 16'h8000, "eq");
    do_op(4'd11, 16'h8000, 16'd1, "lt_neg");
    do_op(4'd15, 16'h0000, 16'h8001, "shl_b");
    do_op(4'd12, 16'h8001, 16'h0000, "shr_a");
    do_op(4'd13, 16'hC001, 16'h0000, "shl_a");
    do_op(4'd14, 16'h0000, 16'h8003, "shr_b");
    do_op(4'd8, 16'hFFFF, 16'hFFFF, "nop");

    idle();
    @(negedge CLK);
    ALU_FUN   = 4'd0;
    A         = 16'd100;
    B         = -16'sd50;
    IN_VALID  = 1'b1;
    OUT_READY = 1'b0;
    e = model(4'd0, 16'd100, -16'sd50);
    chk("hold/in_ready", IN_READY, 1);
    @(posedge CLK);
    #1;
    ALU_FUN = 4'd2;
    A = 16'd7;
    B = 16'd9;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d/valid", i), OUT_VALID, 1);
      chk($sformatf("hold%0d/result", i), RESULT, e.res);
      chk($sformatf("hold%0d/in_ready", i), IN_READY, 0);
      @(posedge CLK);
      #1;
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    @(posedge CLK);
    #1;
    chk("hold/valid_clear", OUT_VALID, 0);

    @(negedge CLK);
    ALU_FUN  = 4'd3;
    A        = -16'sd7;
    B        = 16'd2;
    IN_VALID = 1'b1;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("mid_rst/in_ready", IN_READY, 0);
    chk("mid_rst/out_valid", OUT_VALID, 0);
    chk("mid_rst/result", RESULT, 0);
    chk("mid_rst/unit", UNIT_FLAG, 0);
    chk("mid_rst/ovf", OVF, 0);
    chk("mid_rst/dz", DIV_ZERO, 0);
    chk("mid_rst/busy", BUSY, 0);
    @(negedge CLK);
    RST = 1'b0;
    do_op(4'd0, 16'd1234, 16'd4321, "post_rst_add");

    for (int i = 0; i < 150; i++) begin
      rf = 4'($urandom_range(0, 15));
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 7) == 0) rb = '0;
      if ($urandom_range(0, 15) == 0) begin
        ra = 16'h8000;
        rb = 16'hFFFF;
      end
      do_op(rf, ra, rb, $sformatf("rnd%0d_f%0d", i, rf));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
